// File: rtl/issue_splitter_if.sv
// Handshake/bus bundle between the decoder, the issue splitter and the instruction queue.
// slave: splitter view; master: environment (decoder + queue) view.
interface issue_splitter_if #(
  parameter int unsigned REPEAT_BITS = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_instr_type;
  logic [REPEAT_BITS-1:0] in_repeat;
  logic [10:0]            in_cache_addr;
  logic [10:0]            in_d_cache_addr;
  logic [6:0]             in_main_mem_addr;
  logic [6:0]             in_d_main_mem_addr;
  logic [8:0]             in_arith_instr;
  logic [2:0]             in_ram_instr;
  logic [6:0]             in_ld_st_instr;

  logic                   iq_we;
  logic [1:0]             iq_instr_type;
  logic [4:0]             iq_copy_count;
  logic [10:0]            iq_cache_addr;
  logic [10:0]            iq_d_cache_addr;
  logic [6:0]             iq_main_mem_addr;
  logic [6:0]             iq_d_main_mem_addr;
  logic [8:0]             iq_arith_instr;
  logic [2:0]             iq_ram_instr;
  logic [6:0]             iq_ld_st_instr;
  logic                   iq_needs_reset;
  logic                   iq_reset_req;

  modport slave (
    input  in_valid, in_instr_type, in_repeat, in_cache_addr, in_d_cache_addr,
           in_main_mem_addr, in_d_main_mem_addr, in_arith_instr, in_ram_instr,
           in_ld_st_instr, iq_needs_reset,
    output in_ready, iq_we, iq_instr_type, iq_copy_count, iq_cache_addr,
           iq_d_cache_addr, iq_main_mem_addr, iq_d_main_mem_addr, iq_arith_instr,
           iq_ram_instr, iq_ld_st_instr, iq_reset_req
  );

  modport master (
    output in_valid, in_instr_type, in_repeat, in_cache_addr, in_d_cache_addr,
           in_main_mem_addr, in_d_main_mem_addr, in_arith_instr, in_ram_instr,
           in_ld_st_instr, iq_needs_reset,
    input  in_ready, iq_we, iq_instr_type, iq_copy_count, iq_cache_addr,
           iq_d_cache_addr, iq_main_mem_addr, iq_d_main_mem_addr, iq_arith_instr,
           iq_ram_instr, iq_ld_st_instr, iq_reset_req
  );
endinterface

// File: rtl/issue_splitter.sv
// Splits one repeated instruction into queue pushes of up to GROUP_MAX copies with precomputed bases.
// Optional performance counters: define ISSUE_SPLITTER_PERF_EN.
module issue_splitter #(
  parameter int unsigned GROUP_MAX   = 16,
  parameter int unsigned REPEAT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  issue_splitter_if.slave     bus,
  output logic [31:0]         perf_groups,
  output logic [31:0]         perf_stalls
);
  localparam int unsigned GSHIFT = $clog2(GROUP_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_e;

  typedef struct packed {
    logic [1:0]  instr_type;
    logic [10:0] d_cache;
    logic [6:0]  d_mm;
    logic [8:0]  arith;
    logic [2:0]  ram;
    logic [6:0]  ld_st;
  } instr_t;

  typedef struct packed {
    logic [1:0]  instr_type;
    logic [4:0]  count;
    logic [10:0] cache;
    logic [10:0] d_cache;
    logic [6:0]  mm;
    logic [6:0]  d_mm;
    logic [8:0]  arith;
    logic [2:0]  ram;
    logic [6:0]  ld_st;
  } group_t;

  state_e                 state_q, state_d;
  logic [REPEAT_BITS-1:0] remaining_q, remaining_d;
  logic [10:0]            cache_acc_q, cache_acc_d;
  logic [6:0]             mm_acc_q, mm_acc_d;
  instr_t                 instr_q, instr_d;
  group_t                 grp_q, grp_d;
  logic                   we_q, we_d;

  logic [4:0]             cnt;
  logic [10:0]            cache_step;
  logic [6:0]             mm_step;

  assign cnt        = (remaining_q >= REPEAT_BITS'(GROUP_MAX)) ? 5'(GROUP_MAX) : 5'(remaining_q);
  assign cache_step = instr_q.d_cache << GSHIFT;
  assign mm_step    = instr_q.d_mm << GSHIFT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cache_acc_q <= '0;
      mm_acc_q    <= '0;
      instr_q     <= '0;
      grp_q       <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cache_acc_q <= cache_acc_d;
      mm_acc_q    <= mm_acc_d;
      instr_q     <= instr_d;
      grp_q       <= grp_d;
      we_q        <= we_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cache_acc_d = cache_acc_q;
    mm_acc_d    = mm_acc_q;
    instr_d     = instr_q;
    grp_d       = grp_q;
    we_d        = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero repeat count is accepted here and simply dropped.
        if (bus.in_valid && (bus.in_repeat != '0)) begin
          instr_d     = '{instr_type: bus.in_instr_type, d_cache: bus.in_d_cache_addr,
                          d_mm: bus.in_d_main_mem_addr, arith: bus.in_arith_instr,
                          ram: bus.in_ram_instr, ld_st: bus.in_ld_st_instr};
          remaining_d = bus.in_repeat;
          cache_acc_d = bus.in_cache_addr;
          mm_acc_d    = bus.in_main_mem_addr;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.iq_needs_reset) begin
          state_d = HOLD;
        end else begin
          we_d        = 1'b1;
          grp_d       = '{instr_type: instr_q.instr_type, count: cnt, cache: cache_acc_q,
                          d_cache: instr_q.d_cache, mm: mm_acc_q, d_mm: instr_q.d_mm,
                          arith: instr_q.arith, ram: instr_q.ram, ld_st: instr_q.ld_st};
          cache_acc_d = cache_acc_q + cache_step;
          mm_acc_d    = mm_acc_q + mm_step;
          remaining_d = remaining_q - REPEAT_BITS'(cnt);
          if (remaining_d == '0) state_d = IDLE;
        end
      end
      HOLD:    state_d = WAIT;
      WAIT:    if (!bus.iq_needs_reset) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready           = (state_q == IDLE);
  assign bus.iq_reset_req       = (state_q == HOLD);
  assign bus.iq_we              = we_q;
  assign bus.iq_instr_type      = grp_q.instr_type;
  assign bus.iq_copy_count      = grp_q.count;
  assign bus.iq_cache_addr      = grp_q.cache;
  assign bus.iq_d_cache_addr    = grp_q.d_cache;
  assign bus.iq_main_mem_addr   = grp_q.mm;
  assign bus.iq_d_main_mem_addr = grp_q.d_mm;
  assign bus.iq_arith_instr     = grp_q.arith;
  assign bus.iq_ram_instr       = grp_q.ram;
  assign bus.iq_ld_st_instr     = grp_q.ld_st;

`ifdef ISSUE_SPLITTER_PERF_EN
  logic [31:0] perf_groups_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_groups_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (we_d) perf_groups_q <= perf_groups_q + 32'd1;
      if ((state_q == HOLD) || (state_q == WAIT)) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_groups = perf_groups_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_groups = '0;
  assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_issue_splitter.sv
// Directed self-checking bench for issue_splitter; expected values are hand-computed per scenario.
module tb_issue_splitter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] perf_groups, perf_stalls;
  int          tests = 0;
  int          fails = 0;

  issue_splitter_if #(.REPEAT_BITS(16)) bus();

  issue_splitter #(.GROUP_MAX(16), .REPEAT_BITS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .perf_groups(perf_groups), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Presents one instruction for a single edge; returns at the negedge after it was sampled.
  task automatic drive_instr(input logic [1:0] t, input logic [15:0] r, input logic [10:0] ca,
                             input logic [10:0] dca, input logic [6:0] mm, input logic [6:0] dmm);
    bus.in_valid           = 1'b1;
    bus.in_instr_type      = t;
    bus.in_repeat          = r;
    bus.in_cache_addr      = ca;
    bus.in_d_cache_addr    = dca;
    bus.in_main_mem_addr   = mm;
    bus.in_d_main_mem_addr = dmm;
    bus.in_arith_instr     = 9'h1A5;
    bus.in_ram_instr       = 3'h5;
    bus.in_ld_st_instr     = 7'h5A;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    @(negedge clk);
    @(negedge clk);
    outs = {bus.iq_we, bus.iq_instr_type, bus.iq_copy_count, bus.iq_cache_addr, bus.iq_d_cache_addr,
            bus.iq_main_mem_addr, bus.iq_d_main_mem_addr, bus.iq_arith_instr, bus.iq_ram_instr,
            bus.iq_ld_st_instr, bus.iq_reset_req};
    tests++;
    if (outs !== 64'd0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    tests++;
    if ({perf_groups, perf_stalls} !== 64'd0) begin
      fails++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_groups, perf_stalls);
    end
    reset = 1'b1;
  endtask

  task automatic test_split();
    logic [4:0]  exp_cnt [3] = '{5'd16, 5'd16, 5'd8};
    logic [10:0] exp_ca  [3] = '{11'd100, 11'd132, 11'd164};
    logic [6:0]  exp_mm  [3] = '{7'd5, 7'd53, 7'd101};
    drive_instr(2'd1, 16'd40, 11'd100, 11'd2, 7'd5, 7'd3);
    tests++;
    if (bus.iq_we !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL split_accept: we=%b ready=%b expected 0/0", bus.iq_we, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.iq_we !== 1'b1 || bus.iq_copy_count !== exp_cnt[i]) begin
        fails++; $display("FAIL split_count[%0d]: we=%b cnt=%0d expected 1/%0d", i, bus.iq_we, bus.iq_copy_count, exp_cnt[i]);
      end
      tests++;
      if (bus.iq_cache_addr !== exp_ca[i] || bus.iq_main_mem_addr !== exp_mm[i]) begin
        fails++; $display("FAIL split_addr[%0d]: ca=%0d mm=%0d expected %0d/%0d", i, bus.iq_cache_addr, bus.iq_main_mem_addr, exp_ca[i], exp_mm[i]);
      end
      tests++;
      if ({bus.iq_instr_type, bus.iq_d_cache_addr, bus.iq_d_main_mem_addr, bus.iq_arith_instr, bus.iq_ram_instr, bus.iq_ld_st_instr}
          !== {2'd1, 11'd2, 7'd3, 9'h1A5, 3'h5, 7'h5A}) begin
        fails++; $display("FAIL split_fields[%0d]: type=%0d dca=%0d dmm=%0d arith=%h ram=%h ldst=%h", i,
                          bus.iq_instr_type, bus.iq_d_cache_addr, bus.iq_d_main_mem_addr, bus.iq_arith_instr, bus.iq_ram_instr, bus.iq_ld_st_instr);
      end
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL split_ready_last: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    tests++;
    if (bus.iq_we !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL split_done: we=%b ready=%b expected 0/1", bus.iq_we, bus.in_ready);
    end
  endtask

  task automatic test_zero_repeat();
    drive_instr(2'd2, 16'd0, 11'd7, 11'd7, 7'd7, 7'd7);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.iq_we !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL zero_repeat[%0d]: we=%b ready=%b expected 0/1", i, bus.iq_we, bus.in_ready);
      end
      @(negedge clk);
    end
    tests++;
    if (bus.iq_cache_addr !== 11'd164 || bus.iq_copy_count !== 5'd8) begin
      fails++; $display("FAIL zero_hold: ca=%0d cnt=%0d expected 164/8", bus.iq_cache_addr, bus.iq_copy_count);
    end
  endtask

  task automatic test_wrap();
    logic [6:0] exp_mm [2] = '{7'd120, 7'd8};
    drive_instr(2'd0, 16'd32, 11'd0, 11'd0, 7'd120, 7'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (bus.iq_we !== 1'b1 || bus.iq_main_mem_addr !== exp_mm[i] || bus.iq_copy_count !== 5'd16 || bus.iq_instr_type !== 2'd0) begin
        fails++; $display("FAIL wrap[%0d]: we=%b mm=%0d cnt=%0d type=%0d expected 1/%0d/16/0", i,
                          bus.iq_we, bus.iq_main_mem_addr, bus.iq_copy_count, bus.iq_instr_type, exp_mm[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (bus.iq_we !== 1'b0) begin fails++; $display("FAIL wrap_end: we=%b expected 0", bus.iq_we); end
  endtask

  task automatic test_stall();
    logic [10:0] exp_ca [3] = '{11'd10, 11'd26, 11'd42};
    logic [6:0]  exp_mm [3] = '{7'd0, 7'd16, 7'd32};
    int reqs = 0;
    int pushes = 0;
    do_reset();
    drive_instr(2'd1, 16'd48, 11'd10, 11'd1, 7'd0, 7'd1);
    @(negedge clk);
    tests++;
    if (bus.iq_we !== 1'b1 || bus.iq_cache_addr !== exp_ca[0] || bus.iq_main_mem_addr !== exp_mm[0]) begin
      fails++; $display("FAIL stall_g0: we=%b ca=%0d mm=%0d expected 1/%0d/%0d", bus.iq_we, bus.iq_cache_addr, bus.iq_main_mem_addr, exp_ca[0], exp_mm[0]);
    end
    bus.iq_needs_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.iq_reset_req === 1'b1) reqs++;
      if (bus.iq_we === 1'b1) pushes++;
      if (i == 3) bus.iq_needs_reset = 1'b0;
    end
    tests++;
    if (reqs != 1 || pushes != 0) begin
      fails++; $display("FAIL stall_window: reset_req pulses=%0d pushes=%0d expected 1/0", reqs, pushes);
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.iq_we !== 1'b1 || bus.iq_cache_addr !== exp_ca[i] || bus.iq_main_mem_addr !== exp_mm[i] || bus.iq_reset_req !== 1'b0) begin
        fails++; $display("FAIL stall_g%0d: we=%b ca=%0d mm=%0d req=%b expected 1/%0d/%0d/0", i,
                          bus.iq_we, bus.iq_cache_addr, bus.iq_main_mem_addr, bus.iq_reset_req, exp_ca[i], exp_mm[i]);
      end
    end
    tests++;
`ifdef ISSUE_SPLITTER_PERF_EN
    if (perf_stalls !== 32'd4) begin fails++; $display("FAIL stall_perf: got %0d expected 4", perf_stalls); end
`else
    if (perf_stalls !== 32'd0) begin fails++; $display("FAIL stall_perf: got %0d expected 0", perf_stalls); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [63:0] outs;
    int pushes = 0;
    drive_instr(2'd2, 16'd64, 11'd200, 11'd1, 7'd0, 7'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.iq_we !== 1'b1 || bus.iq_cache_addr !== 11'd232) begin
      fails++; $display("FAIL rstmid_g2: we=%b ca=%0d expected 1/232", bus.iq_we, bus.iq_cache_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    outs = {bus.iq_we, bus.iq_instr_type, bus.iq_copy_count, bus.iq_cache_addr, bus.iq_d_cache_addr,
            bus.iq_main_mem_addr, bus.iq_d_main_mem_addr, bus.iq_arith_instr, bus.iq_ram_instr,
            bus.iq_ld_st_instr, bus.iq_reset_req};
    tests++;
    if (outs !== 64'd0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_clear: outs=%h ready=%b expected 0/1", outs, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.iq_we === 1'b1) pushes++;
    end
    tests++;
    if (pushes != 0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_after: pushes=%0d ready=%b expected 0/1", pushes, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_instr(2'd2, 16'd16, 11'd7, 11'd0, 7'd3, 7'd0);
    @(negedge clk);
    tests++;
    if (bus.iq_we !== 1'b1 || bus.iq_copy_count !== 5'd16 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_first: we=%b cnt=%0d ready=%b expected 1/16/1", bus.iq_we, bus.iq_copy_count, bus.in_ready);
    end
    drive_instr(2'd0, 16'd1, 11'd9, 11'd0, 7'd4, 7'd0);
    tests++;
    if (bus.iq_we !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_bubble: we=%b ready=%b expected 0/0", bus.iq_we, bus.in_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.iq_we !== 1'b1 || bus.iq_copy_count !== 5'd1 || bus.iq_cache_addr !== 11'd9 || bus.iq_instr_type !== 2'd0) begin
      fails++; $display("FAIL b2b_second: we=%b cnt=%0d ca=%0d type=%0d expected 1/1/9/0", bus.iq_we, bus.iq_copy_count, bus.iq_cache_addr, bus.iq_instr_type);
    end
    tests++;
`ifdef ISSUE_SPLITTER_PERF_EN
    if (perf_groups !== 32'd2) begin fails++; $display("FAIL b2b_perf: got %0d expected 2", perf_groups); end
`else
    if (perf_groups !== 32'd0) begin fails++; $display("FAIL b2b_perf: got %0d expected 0", perf_groups); end
`endif
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid           = 1'b0;
    bus.in_instr_type      = '0;
    bus.in_repeat          = '0;
    bus.in_cache_addr      = '0;
    bus.in_d_cache_addr    = '0;
    bus.in_main_mem_addr   = '0;
    bus.in_d_main_mem_addr = '0;
    bus.in_arith_instr     = '0;
    bus.in_ram_instr       = '0;
    bus.in_ld_st_instr     = '0;
    bus.iq_needs_reset     = 1'b0;
    test_reset();
    test_split();
    test_zero_repeat();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
